// File: rtl/nms_window_ctrl_pkg.sv
// Shared types and defaults for the Canny NMS window path.
// The pixel layout is common to the window generator and the NMS stage.
package nms_window_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun,
    StDrain
  } state_e;

  localparam int unsigned DefWidth  = 636;
  localparam int unsigned DefDepth  = 508;
  localparam int unsigned DataWidth = 26;
  localparam int unsigned DirMsb    = 25;
  localparam int unsigned DirLsb    = 24;
  localparam int unsigned MagMsb    = 23;
  localparam int unsigned MagLsb    = 0;

  typedef struct packed {
    logic [DirMsb-DirLsb:0] dir;
    logic [MagMsb-MagLsb:0] mag;
  } pixel_t;

endpackage

// File: rtl/nms_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle between gradient stage, window generator and NMS.
// The master modport is the controller's view; slave is the surrounding pipeline.
interface nms_window_ctrl_if #(
   parameter int unsigned CW = 10,
   parameter int unsigned RW = 10
);
   logic          in_valid;
   logic          in_ready;
   logic          shift_en;
   logic          win_start;
   logic          win_valid;
   logic          win_ready;
   logic [RW-1:0] win_row;
   logic [CW-1:0] win_col;
   logic          win_last;

   modport master (
      input  in_valid, win_ready,
      output in_ready, shift_en, win_start, win_valid, win_row, win_col, win_last
   );

   modport slave (
      output in_valid, win_ready,
      input  in_ready, shift_en, win_start, win_valid, win_row, win_col, win_last
   );
endinterface

// File: rtl/nms_window_ctrl_raster_counter.sv
// Raster column/row position of the pixel currently offered upstream.
// Column wraps at WIDTH-1; row advances on column wrap and wraps after the last line.
module nms_window_ctrl_raster_counter #(
   parameter int unsigned WIDTH = 636,
   parameter int unsigned DEPTH = 508,
   parameter int unsigned CW    = 10,
   parameter int unsigned RW    = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clear,
   input  logic          i_step,
   output logic [CW-1:0] o_col,
   output logic [RW-1:0] o_row,
   output logic          o_col_last,
   output logic          o_frame_last
);
   logic [CW-1:0] r_col, w_col_nxt;
   logic [RW-1:0] r_row, w_row_nxt;
   logic          w_col_last, w_row_last;

   assign w_col_last = (r_col == CW'(WIDTH - 1));
   assign w_row_last = (r_row == RW'(DEPTH - 1));

   always_comb begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
      if (i_clear) begin
         w_col_nxt = '0;
         w_row_nxt = '0;
      end else if (i_step) begin
         if (w_col_last) begin
            w_col_nxt = '0;
            w_row_nxt = w_row_last ? '0 : r_row + RW'(1);
         end else begin
            w_col_nxt = r_col + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
      end
   end

   assign o_col        = r_col;
   assign o_row        = r_row;
   assign o_col_last   = w_col_last;
   assign o_frame_last = w_col_last && w_row_last;
endmodule

// File: rtl/nms_window_ctrl.sv
// Sequencer for the 3x3 window generator feeding NMS: accepts pixels, tracks raster
// position and presents one window event per interior centre pixel with backpressure.
module nms_window_ctrl
   import nms_window_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned DEPTH = DefDepth,
   parameter int unsigned CW    = 10,
   parameter int unsigned RW    = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_frame_start,
   input  logic                     i_abort,
   nms_window_ctrl_if.master        win_if,
   output logic                     o_frame_done,
   output logic                     o_busy,
   output logic                     o_start_err
);
   state_e        r_state, w_state_nxt;
   logic [CW-1:0] w_col;
   logic [RW-1:0] w_row;
   logic          w_col_last, w_frame_last;
   logic          w_active, w_in_ready, w_shift, w_emit, w_consume, w_done, w_clear;
   logic          r_win_valid, r_win_last, r_frame_done, r_start_err;
   logic [RW-1:0] r_win_row;
   logic [CW-1:0] r_win_col;

   assign w_active   = (r_state == StPrime) || (r_state == StRun);
   // A held window blocks new pixels so the generator matrix is never overwritten.
   assign w_in_ready = w_active && (!r_win_valid || win_if.win_ready);
   assign w_shift    = win_if.in_valid && w_in_ready;
   assign w_emit     = w_shift && (w_row >= RW'(2)) && (w_col >= CW'(2));
   assign w_consume  = r_win_valid && win_if.win_ready;
   assign w_done     = !i_abort && (r_state == StDrain) && w_consume && r_win_last;
   assign w_clear    = i_abort || w_done || ((r_state == StIdle) && i_frame_start);

   nms_window_ctrl_raster_counter #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CW    (CW),
      .RW    (RW)
   ) u_raster_counter (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (w_clear),
      .i_step       (w_shift),
      .o_col        (w_col),
      .o_row        (w_row),
      .o_col_last   (w_col_last),
      .o_frame_last (w_frame_last)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (i_abort) begin
         w_state_nxt = StIdle;
      end else begin
         unique case (r_state)
            StIdle:  if (i_frame_start) w_state_nxt = StPrime;
            StPrime: if (w_shift && (w_row == RW'(1)) && w_col_last) w_state_nxt = StRun;
            StRun:   if (w_shift && w_frame_last) w_state_nxt = StDrain;
            StDrain: if (w_done) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_valid  <= 1'b0;
         r_win_row    <= '0;
         r_win_col    <= '0;
         r_win_last   <= 1'b0;
         r_frame_done <= 1'b0;
         r_start_err  <= 1'b0;
      end else begin
         r_frame_done <= w_done;
         r_start_err  <= i_frame_start && !i_abort && (r_state != StIdle);
         if (i_abort) begin
            r_win_valid <= 1'b0;
         end else if (w_emit) begin
            r_win_valid <= 1'b1;
            r_win_row   <= w_row - RW'(1);
            r_win_col   <= w_col - CW'(1);
            r_win_last  <= w_frame_last;
         end else if (w_consume) begin
            r_win_valid <= 1'b0;
         end
      end
   end

   assign win_if.in_ready  = w_in_ready;
   assign win_if.shift_en  = w_shift;
   assign win_if.win_start = (r_state != StIdle);
   assign win_if.win_valid = r_win_valid;
   assign win_if.win_row   = r_win_row;
   assign win_if.win_col   = r_win_col;
   assign win_if.win_last  = r_win_last;
   assign o_frame_done     = r_frame_done;
   assign o_busy           = (r_state != StIdle);
   assign o_start_err      = r_start_err;
endmodule
